// File: rtl/pool_reduce_param.sv
// Window pooling unit: reduces one packed window of WIN signed elements to a
// single clamped, narrowed activation using max or average pooling.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset, clears all state
//   start_flag - one-cycle pulse, window on `in` and `mode` valid this cycle
//   mode       - 0 = max pool, 1 = average pool (sampled with start_flag)
//   in         - packed window, element 0 in the top IN_W bits
//   out        - {sign, low OUT_W-1 bits} of the clamped result
//   end_flag   - one-cycle pulse, out updated and valid
//   busy       - high while a window is being reduced or clamped
module pool_reduce_param #(
  parameter int unsigned IN_W      = 15,
  parameter int unsigned WIN       = 4,
  parameter int unsigned OUT_W     = 4,
  parameter int          CLAMP_MIN = 0,
  parameter int          CLAMP_MAX = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_flag,
  input  logic                 mode,
  input  logic [IN_W*WIN-1:0]  in,
  output logic [OUT_W-1:0]     out,
  output logic                 end_flag,
  output logic                 busy
);

  localparam int unsigned LOGW  = $clog2(WIN);
  localparam int unsigned ACC_W = IN_W + LOGW;
  localparam int unsigned TOP   = IN_W * WIN - 1;

  localparam logic signed [ACC_W-1:0] CMIN = ACC_W'(CLAMP_MIN);
  localparam logic signed [ACC_W-1:0] CMAX = ACC_W'(CLAMP_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_CLAMP
  } state_e;

  state_e                    state_q;
  logic [IN_W*WIN-1:0]       win_q;
  logic                      mode_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [LOGW-1:0]           idx_q;
  logic [OUT_W-1:0]          res_q;
  logic                      end_q;
  logic                      busy_q;

  logic signed [ACC_W-1:0]   first_c;
  logic signed [ACC_W-1:0]   elem_c;
  logic signed [ACC_W-1:0]   v_c;

  // Window is consumed from the top: the element under processing always
  // sits in the top IN_W bits of win_q, so no variable indexing is needed.
  always_comb begin
    first_c = {{LOGW{in[TOP]}}, in[TOP -: IN_W]};
    elem_c  = {{LOGW{win_q[TOP]}}, win_q[TOP -: IN_W]};
    v_c     = mode_q ? (acc_q >>> LOGW) : acc_q;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      end_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_flag) begin
            win_q   <= in << IN_W;
            mode_q  <= mode;
            acc_q   <= first_c;
            idx_q   <= LOGW'(1);
            busy_q  <= 1'b1;
            state_q <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (mode_q) begin
            acc_q <= acc_q + elem_c;
          end else if (elem_c > acc_q) begin
            acc_q <= elem_c;
          end
          win_q <= win_q << IN_W;
          idx_q <= idx_q + LOGW'(1);
          if (idx_q == LOGW'(WIN - 1)) begin
            state_q <= S_CLAMP;
          end
        end
        S_CLAMP: begin
          // Sign bit kept in the output format even though clamping keeps it 0
          if (v_c <= CMIN) begin
            res_q <= {CMIN[IN_W-1], CMIN[OUT_W-2:0]};
          end else if (v_c >= CMAX) begin
            res_q <= {CMAX[IN_W-1], CMAX[OUT_W-2:0]};
          end else begin
            res_q <= {v_c[IN_W-1], v_c[OUT_W-2:0]};
          end
          end_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out      = res_q;
  assign end_flag = end_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pool_reduce_param.sv
module tb_pool_reduce_param;

  localparam int IA = 15, WA = 4, OA = 4;
  localparam int IB = 12, WB = 16, OB = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start_a, mode_a, end_a, busy_a;
  logic [IA*WA-1:0]  in_a;
  logic [OA-1:0]     out_a;
  logic              start_b, mode_b, end_b, busy_b;
  logic [IB*WB-1:0]  in_b;
  logic [OB-1:0]     out_b;

  pool_reduce_param dut_a (
    .clk(clk), .reset(reset), .start_flag(start_a), .mode(mode_a), .in(in_a),
    .out(out_a), .end_flag(end_a), .busy(busy_a)
  );

  pool_reduce_param #(
    .IN_W(12), .WIN(16), .OUT_W(6), .CLAMP_MIN(0), .CLAMP_MAX(31)
  ) dut_b (
    .clk(clk), .reset(reset), .start_flag(start_b), .mode(mode_b), .in(in_b),
    .out(out_b), .end_flag(end_b), .busy(busy_b)
  );

  int nvec = 0;
  int nerr = 0;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain max or floor-average of the integer window, then clamp.
  function automatic int ref_pool(input int e[$], input bit m, input int lo, input int hi);
    int v, s, n;
    n = e.size();
    if (!m) begin
      v = e[0];
      foreach (e[i]) if (e[i] > v) v = e[i];
    end else begin
      s = 0;
      foreach (e[i]) s += e[i];
      v = (s >= 0) ? s / n : -((-s + n - 1) / n);
    end
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return v;
  endfunction

  task automatic drive_a(input int e[$], input bit m);
    int t;
    for (int i = 0; i < WA; i++) begin
      t = e[i];
      in_a[IA*(WA-1-i) +: IA] = t[IA-1:0];
    end
    mode_a  = m;
    start_a = 1'b1;
  endtask

  task automatic run_a(input int e[$], input bit m, input string tag);
    int lat;
    @(negedge clk);
    drive_a(e, m);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    mode_a  = ~m;
    in_a    = (IA*WA)'({$urandom(), $urandom()});
    chk({tag, "/busy"}, 32'(busy_a), 32'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (end_a) begin lat = k; break; end
    end
    chk({tag, "/latency"}, 32'(lat), 32'(WA));
    chk({tag, "/out"}, 32'(out_a), 32'(ref_pool(e, m, 0, 7)));
    chk({tag, "/busy_end"}, 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "/end_pulse"}, 32'(end_a), 32'd0);
  endtask

  task automatic run_b(input int e[$], input bit m, input string tag);
    int lat, t;
    @(negedge clk);
    for (int i = 0; i < WB; i++) begin
      t = e[i];
      in_b[IB*(WB-1-i) +: IB] = t[IB-1:0];
    end
    mode_b  = m;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    mode_b  = ~m;
    chk({tag, "/busy"}, 32'(busy_b), 32'd1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (end_b) begin lat = k; break; end
    end
    chk({tag, "/latency"}, 32'(lat), 32'(WB));
    chk({tag, "/out"}, 32'(out_b), 32'(ref_pool(e, m, 0, 31)));
  endtask

  initial begin
    int n_end, first_end, second_end;
    int w3[$];
    reset   = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; in_a = '0;
    start_b = 1'b0; mode_b = 1'b0; in_b = '0;
    #1;
    chk("rst/out_a", 32'(out_a), 32'd0);
    chk("rst/end_a", 32'(end_a), 32'd0);
    chk("rst/busy_a", 32'(busy_a), 32'd0);
    chk("rst/out_b", 32'(out_b), 32'd0);
    chk("rst/busy_b", 32'(busy_b), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed windows on the default instance
    q = {3, 5, 6, 10};     run_a(q, 1'b0, "max_clamp");
    q = {-3, -1, -8, -2};  run_a(q, 1'b0, "max_neg");
    q = {5, 5, 2, 1};      run_a(q, 1'b0, "max_tie");
    q = {3, 5, 6, 10};     run_a(q, 1'b1, "avg_6");
    q = {-3, -1, -8, -2};  run_a(q, 1'b1, "avg_neg");
    q = {1, 2, 2, 2};      run_a(q, 1'b1, "avg_floor");
    q = {-16384, 16383, -16384, -16384}; run_a(q, 1'b0, "max_extreme");
    q = {16383, 16383, 16383, 16383};    run_a(q, 1'b1, "avg_extreme");

    // Random windows on the default instance
    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int i = 0; i < WA; i++) q.push_back(int'($urandom_range(40)) - 20);
      run_a(q, 1'($urandom_range(1)), "rand_a");
    end

    // Back-to-back: ignored start while busy, accepted start during end_flag
    @(negedge clk);
    q = {3, 5, 6, 10};
    drive_a(q, 1'b0);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    w3 = {6, 5, 3, 4};
    n_end = 0; first_end = 0; second_end = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 2) begin
        q = {0, 0, 0, 0};
        drive_a(q, 1'b0);
      end else if (c == 5) begin
        chk("b2b/coincide", 32'(end_a), 32'd1);
        drive_a(w3, 1'b1);
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c == 4) chk("b2b/out1", 32'(out_a), 32'd7);
      if (end_a) begin
        n_end++;
        if (n_end == 1) first_end = c;
        if (n_end == 2) second_end = c;
      end
    end
    chk("b2b/count", 32'(n_end), 32'd2);
    chk("b2b/first", 32'(first_end), 32'd4);
    chk("b2b/second", 32'(second_end), 32'd9);
    chk("b2b/out2", 32'(out_a), 32'(ref_pool(w3, 1'b1, 0, 7)));

    // Asynchronous reset in the middle of REDUCE
    @(negedge clk);
    q = {9, 1, 1, 1};
    drive_a(q, 1'b0);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst/out", 32'(out_a), 32'd0);
    chk("arst/busy", 32'(busy_a), 32'd0);
    chk("arst/end", 32'(end_a), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_end = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (end_a) n_end++;
    end
    chk("arst/no_end", 32'(n_end), 32'd0);
    q = {2, 4, 3, 1};
    run_a(q, 1'b0, "arst/recover");

    // Re-parametrised instance: directed corners
    q.delete();
    for (int i = 0; i < WB; i++) q.push_back((i == 7) ? 100 : i - 8);
    run_b(q, 1'b0, "b/max100");
    q.delete();
    repeat (WB) q.push_back(40);
    run_b(q, 1'b1, "b/avg40");
    q.delete();
    repeat (WB) q.push_back(20);
    run_b(q, 1'b1, "b/avg20");

    // Re-parametrised instance: random windows, narrow and full range
    for (int r = 0; r < 10; r++) begin
      q.delete();
      for (int i = 0; i < WB; i++) begin
        if (r % 2 == 0) q.push_back(int'($urandom_range(79)) - 30);
        else            q.push_back(int'($urandom_range(4095)) - 2048);
      end
      run_b(q, 1'($urandom_range(1)), "rand_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
